fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//   Input stage feeding the 4-bank FFT RAM block. Accepts one complex sample
//   per cycle over a valid/ready stream and writes one frame of N = 4*2^A_BIT
//   samples into the 4 banks in bit-reversed order, ready for in-place
//   butterfly stages. Drives the RAM block's write-side ports
//   (data/addr/WE per bank) and signals frame completion to the FFT sequencer.
// PARAMETERS
//   D_BIT  17  width of each real/imag sample word (matches RAM word)
//   A_BIT  9   per-bank address width; frame length N = 4*2^A_BIT (2048)
// PORTS
//   iCLK           in   1       system clock, all logic on rising edge
//   iRESET         in   1       asynchronous active-high reset
//   iSTART         in   1       start one frame load (sampled in IDLE only)
//   iVALID         in   1       input sample valid
//   iDATA_RE       in   D_BIT   input sample, real part
//   iDATA_IM       in   D_BIT   input sample, imaginary part
//   oREADY         out  1       loader accepts a sample this cycle
//   oBUSY          out  1       frame load in progress (state LOAD)
//   oDONE          out  1       1-cycle pulse: last sample of frame written
//   oDATA_RE_0..3  out  D_BIT   per-bank write data, real -> RAM iDATA_RE_k
//   oDATA_IM_0..3  out  D_BIT   per-bank write data, imag -> RAM iDATA_IM_k
//   oADDR_WR_0..3  out  A_BIT   per-bank write address -> RAM iADDR_WR_k
//   oWE_0..3       out  1       per-bank write enable -> RAM iWE_k
// BEHAVIOUR
//   - Reset (async, iRESET=1): state IDLE, sample counter n=0, all outputs 0.
//   - States: IDLE -> LOAD on iSTART=1; LOAD -> IDLE after the accept of sample
//     N-1. iSTART ignored while in LOAD.
//   - oREADY = (state==LOAD); oBUSY = (state==LOAD). Accept = iVALID & oREADY.
//     iVALID while IDLE is ignored (no write, no count).
//   - Counter n (LOG_N = A_BIT+2 bits) resets to 0 on entry to LOAD and
//     increments by 1 per accept; stalls when iVALID=0 (gaps allowed).
//   - Mapping: r = bit-reverse of n over LOG_N bits; bank b = r[1:0],
//     address = r[LOG_N-1:2].
//   - Outputs are registered, latency 1: a sample accepted in cycle t gives
//     oWE_b=1, oADDR_WR_b=address, oDATA_RE_b/IM_b=sample in cycle t+1.
//   - Exactly one oWE_k high per accepted sample; all WE low otherwise.
//     Data/addr registers of bank k update only when bank k is written and
//     hold their value otherwise.
//   - oDONE=1 in the same cycle as the write of sample N-1 (t+1). oREADY is
//     already 0 in that cycle.
//   - iSTART in the oDONE cycle (state IDLE) starts a new frame. The next
//     accept is then in the cycle after that.
//   - Reset mid-frame: partial frame abandoned, no oDONE, WE deasserted
//     immediately (async). Already-written RAM contents are untouched.
//   - No overflow case: the counter wraps to 0 exactly at the end of the frame.
// TESTING (bench with A_BIT=2, N=16, LOG_N=4)
//   1 Reset: assert iRESET mid-cycle -> all outputs 0 immediately, oREADY=0.
//   2 iSTART, then 16 back-to-back samples re=n, im=-n -> writes
//     n=1: bank0 addr2; n=4: bank2 addr0; n=15: bank3 addr3.
//     All 16 (bank,addr) pairs are distinct; oDONE is a single pulse with
//     the 16th WE.
//   3 Same frame with iVALID toggling 1010... -> identical bank/addr/data
//     sequence, no writes in gap cycles, oDONE with the final write.
//   4 iVALID=1 while IDLE, and iSTART pulses during LOAD -> no writes
//     while IDLE; the frame still ends after exactly 16 accepts.
//   5 iRESET after 7 accepts, then iSTART + 16 samples -> no oDONE for the
//     aborted frame; the new frame restarts at n=0 (bank0 addr0).
//   6 iSTART held high through oDONE -> the second frame loads back-to-back
//     with a single idle cycle; the RAM contents scoreboard matches the
//     bit-reversed order.

Source files
------------

// File: rtl/fft_input_loader.sv
// Input stage of the 4-bank FFT RAM. It takes one frame of N = 4*2^A_BIT complex
// samples from a valid/ready stream and writes them to the banks in bit-reversed order.
module fft_input_loader #(
  parameter int unsigned D_BIT = 17,
  parameter int unsigned A_BIT = 9
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iVALID,
  input  logic [D_BIT-1:0] iDATA_RE,
  input  logic [D_BIT-1:0] iDATA_IM,
  output logic             oREADY,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [D_BIT-1:0] oDATA_RE_0,
  output logic [D_BIT-1:0] oDATA_RE_1,
  output logic [D_BIT-1:0] oDATA_RE_2,
  output logic [D_BIT-1:0] oDATA_RE_3,
  output logic [D_BIT-1:0] oDATA_IM_0,
  output logic [D_BIT-1:0] oDATA_IM_1,
  output logic [D_BIT-1:0] oDATA_IM_2,
  output logic [D_BIT-1:0] oDATA_IM_3,
  output logic [A_BIT-1:0] oADDR_WR_0,
  output logic [A_BIT-1:0] oADDR_WR_1,
  output logic [A_BIT-1:0] oADDR_WR_2,
  output logic [A_BIT-1:0] oADDR_WR_3,
  output logic             oWE_0,
  output logic             oWE_1,
  output logic             oWE_2,
  output logic             oWE_3
);

  localparam int unsigned LOG_N = A_BIT + 2;
  localparam int unsigned NBANK = 4;
  localparam logic [LOG_N-1:0] LAST_N = '1;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] n_q, n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NBANK-1:0] we_q, we_d;
  logic [A_BIT-1:0] addr_q [NBANK];
  logic [A_BIT-1:0] addr_d [NBANK];
  logic [D_BIT-1:0] re_q   [NBANK];
  logic [D_BIT-1:0] re_d   [NBANK];
  logic [D_BIT-1:0] im_q   [NBANK];
  logic [D_BIT-1:0] im_d   [NBANK];

  logic             accept;
  logic [LOG_N-1:0] rev;
  logic [1:0]       bank;

  // Bit-reversed sample index: low two bits pick the bank, the rest is the address.
  always_comb begin
    rev = '0;
    for (int i = 0; i < LOG_N; i++) begin
      rev[i] = n_q[LOG_N-1-i];
    end
    bank   = rev[1:0];
    accept = iVALID && (state_q == ST_LOAD);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    done_d  = 1'b0;
    we_d    = '0;
    for (int k = 0; k < NBANK; k++) begin
      addr_d[k] = addr_q[k];
      re_d[k]   = re_q[k];
      im_d[k]   = im_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        n_d = '0;
        if (iSTART) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d[bank]   = 1'b1;
          addr_d[bank] = rev[LOG_N-1:2];
          re_d[bank]   = iDATA_RE;
          im_d[bank]   = iDATA_IM;
          // Counter wraps to zero exactly on the last sample of the frame.
          n_d          = n_q + LOG_N'(1);
          if (n_q == LAST_N) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '0;
      for (int k = 0; k < NBANK; k++) begin
        addr_q[k] <= '0;
        re_q[k]   <= '0;
        im_q[k]   <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      for (int k = 0; k < NBANK; k++) begin
        addr_q[k] <= addr_d[k];
        re_q[k]   <= re_d[k];
        im_q[k]   <= im_d[k];
      end
    end
  end

  assign oREADY     = busy_q;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oADDR_WR_0 = addr_q[0];
  assign oADDR_WR_1 = addr_q[1];
  assign oADDR_WR_2 = addr_q[2];
  assign oADDR_WR_3 = addr_q[3];
  assign oDATA_RE_0 = re_q[0];
  assign oDATA_RE_1 = re_q[1];
  assign oDATA_RE_2 = re_q[2];
  assign oDATA_RE_3 = re_q[3];
  assign oDATA_IM_0 = im_q[0];
  assign oDATA_IM_1 = im_q[1];
  assign oDATA_IM_2 = im_q[2];
  assign oDATA_IM_3 = im_q[3];

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with A_BIT=2 (N=16): checks bank/address
// mapping, latency, gaps, idle/start handling, mid-frame reset and back-to-back frames.
module tb_fft_input_loader;

  localparam int unsigned D_BIT = 17;
  localparam int unsigned A_BIT = 2;
  localparam int unsigned N     = 16;

  logic             iCLK, iRESET, iSTART, iVALID;
  logic [D_BIT-1:0] iDATA_RE, iDATA_IM;
  logic             oREADY, oBUSY, oDONE;
  logic [D_BIT-1:0] oDATA_RE_0, oDATA_RE_1, oDATA_RE_2, oDATA_RE_3;
  logic [D_BIT-1:0] oDATA_IM_0, oDATA_IM_1, oDATA_IM_2, oDATA_IM_3;
  logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic             oWE_0, oWE_1, oWE_2, oWE_3;
  logic [3:0]       we_v;

  fft_input_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iVALID(iVALID),
    .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM),
    .oREADY(oREADY), .oBUSY(oBUSY), .oDONE(oDONE),
    .oDATA_RE_0(oDATA_RE_0), .oDATA_RE_1(oDATA_RE_1), .oDATA_RE_2(oDATA_RE_2), .oDATA_RE_3(oDATA_RE_3),
    .oDATA_IM_0(oDATA_IM_0), .oDATA_IM_1(oDATA_IM_1), .oDATA_IM_2(oDATA_IM_2), .oDATA_IM_3(oDATA_IM_3),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3)
  );

  assign we_v = {oWE_3, oWE_2, oWE_1, oWE_0};

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks, errors, cyc;
  int wr_n, done_cnt, done_idx;
  logic ready_at_done;
  int wr_bank [64];
  int wr_addr [64];
  int wr_cyc  [64];
  logic [D_BIT-1:0] wr_re [64];
  logic [D_BIT-1:0] wr_im [64];
  logic [D_BIT-1:0] mem_re [4][4];
  logic [D_BIT-1:0] mem_im [4][4];
  int hits [4][4];

  function automatic int exp_rev(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (((n >> i) & 1) != 0) r = r | (1 << (3 - i));
    return r;
  endfunction

  function automatic logic [D_BIT-1:0] neg(input int n);
    logic [D_BIT-1:0] v;
    v = 17'(0) - 17'(n);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic record(input int b);
    int a;
    logic [D_BIT-1:0] re, im;
    case (b)
      0: begin a = int'(oADDR_WR_0); re = oDATA_RE_0; im = oDATA_IM_0; end
      1: begin a = int'(oADDR_WR_1); re = oDATA_RE_1; im = oDATA_IM_1; end
      2: begin a = int'(oADDR_WR_2); re = oDATA_RE_2; im = oDATA_IM_2; end
      default: begin a = int'(oADDR_WR_3); re = oDATA_RE_3; im = oDATA_IM_3; end
    endcase
    if (wr_n < 64) begin
      wr_bank[wr_n] = b; wr_addr[wr_n] = a; wr_re[wr_n] = re; wr_im[wr_n] = im;
      wr_cyc[wr_n] = cyc;
    end
    mem_re[b][a] = re;
    mem_im[b][a] = im;
    hits[b][a]++;
    wr_n++;
  endtask

  task automatic capture();
    int cnt;
    cnt = 0;
    for (int b = 0; b < 4; b++) if (we_v[b]) begin cnt++; record(b); end
    chk("we_onehot", 32'(cnt <= 1), 32'd1);
    if (oDONE) begin
      done_cnt++;
      done_idx = wr_n - 1;
      ready_at_done = oREADY;
    end
  endtask

  task automatic cycle(input logic st, input logic vl, input int n);
    iSTART = st; iVALID = vl;
    iDATA_RE = 17'(n); iDATA_IM = neg(n);
    @(posedge iCLK); #1;
    cyc++;
    capture();
  endtask

  task automatic clear_log();
    wr_n = 0; done_cnt = 0; done_idx = -1; ready_at_done = 1'b1;
    for (int b = 0; b < 4; b++) for (int a = 0; a < 4; a++) hits[b][a] = 0;
  endtask

  task automatic check_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bank_w%0d", base + i), 32'(wr_bank[base + i]), 32'(exp_rev(i) & 3));
      chk($sformatf("addr_w%0d", base + i), 32'(wr_addr[base + i]), 32'(exp_rev(i) >> 2));
      chk($sformatf("re_w%0d", base + i), 32'(wr_re[base + i]), 32'(i));
      chk($sformatf("im_w%0d", base + i), 32'(wr_im[base + i]), 32'(neg(i)));
    end
  endtask

  task automatic check_hits(input int n);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) chk($sformatf("hits_b%0d_a%0d", b, a), 32'(hits[b][a]), 32'(n));
  endtask

  task automatic check_done(input string tag, input int idx);
    chk({tag, "_writes"}, 32'(wr_n), 32'(idx + 1));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_idx"}, 32'(done_idx), 32'(idx));
    chk({tag, "_ready_at_done"}, 32'(ready_at_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    iRESET = 1'b0; iSTART = 1'b0; iVALID = 1'b0; iDATA_RE = '0; iDATA_IM = '0;
    clear_log();

    // 1: async reset mid-cycle, before any clock edge
    #3 iRESET = 1'b1;
    #1;
    chk("rst_we", 32'(we_v), 32'd0);
    chk("rst_ready", 32'(oREADY), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    chk("rst_addr3", 32'(oADDR_WR_3), 32'd0);
    chk("rst_re0", 32'(oDATA_RE_0), 32'd0);
    chk("rst_im2", 32'(oDATA_IM_2), 32'd0);
    @(posedge iCLK); @(posedge iCLK); #1 iRESET = 1'b0;
    cycle(1'b0, 1'b0, 0);
    chk("idle_ready", 32'(oREADY), 32'd0);

    // 2: back-to-back frame
    clear_log();
    cycle(1'b1, 1'b0, 0);
    chk("t2_ready", 32'(oREADY), 32'd1);
    chk("t2_busy", 32'(oBUSY), 32'd1);
    for (int n = 0; n < 16; n++) cycle(1'b0, 1'b1, n);
    check_done("t2", 15);
    chk("t2_n1_bank", 32'(wr_bank[1]), 32'd0);
    chk("t2_n1_addr", 32'(wr_addr[1]), 32'd2);
    chk("t2_n4_bank", 32'(wr_bank[4]), 32'd2);
    chk("t2_n4_addr", 32'(wr_addr[4]), 32'd0);
    chk("t2_n15_bank", 32'(wr_bank[15]), 32'd3);
    chk("t2_n15_addr", 32'(wr_addr[15]), 32'd3);
    check_frame(0);
    check_hits(1);
    cycle(1'b0, 1'b0, 0);
    chk("t2_single_done", 32'(done_cnt), 32'd1);
    chk("t2_idle_busy", 32'(oBUSY), 32'd0);

    // 3: iVALID toggling 1010...
    clear_log();
    cycle(1'b1, 1'b0, 0);
    for (int n = 0; n < 16; n++) begin
      cycle(1'b0, 1'b1, n);
      if (n != 15) begin
        cycle(1'b0, 1'b0, 0);
        chk("t3_gap_we", 32'(we_v), 32'd0);
      end
    end
    check_done("t3", 15);
    check_frame(0);
    check_hits(1);

    // 4: valid while idle, start pulses during load
    clear_log();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 99);
      chk("t4_idle_we", 32'(we_v), 32'd0);
      chk("t4_idle_ready", 32'(oREADY), 32'd0);
    end
    chk("t4_idle_writes", 32'(wr_n), 32'd0);
    cycle(1'b1, 1'b0, 0);
    for (int n = 0; n < 16; n++) cycle((n % 2) == 0, 1'b1, n);
    check_done("t4", 15);
    check_frame(0);
    cycle(1'b0, 1'b1, 77);
    chk("t4_no_extra", 32'(wr_n), 32'd16);
    chk("t4_post_busy", 32'(oBUSY), 32'd0);

    // 5: reset after 7 accepts, then a fresh frame
    clear_log();
    cycle(1'b1, 1'b0, 0);
    for (int n = 0; n < 7; n++) cycle(1'b0, 1'b1, n);
    chk("t5_partial_writes", 32'(wr_n), 32'd7);
    chk("t5_we_before_rst", 32'(we_v), 32'b0100);
    iVALID = 1'b0;
    #1 iRESET = 1'b1;
    #1;
    chk("t5_abort_we", 32'(we_v), 32'd0);
    chk("t5_abort_ready", 32'(oREADY), 32'd0);
    chk("t5_abort_busy", 32'(oBUSY), 32'd0);
    chk("t5_abort_done", 32'(oDONE), 32'd0);
    @(posedge iCLK); #1 iRESET = 1'b0;
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    clear_log();
    cycle(1'b1, 1'b0, 0);
    for (int n = 0; n < 16; n++) cycle(1'b0, 1'b1, n);
    chk("t5_first_bank", 32'(wr_bank[0]), 32'd0);
    chk("t5_first_addr", 32'(wr_addr[0]), 32'd0);
    check_done("t5", 15);
    check_frame(0);

    // 6: iSTART held through oDONE -> two frames with one idle cycle
    clear_log();
    cycle(1'b1, 1'b0, 0);
    for (int n = 0; n < 16; n++) cycle(1'b1, 1'b1, n);
    check_done("t6a", 15);
    cycle(1'b1, 1'b0, 0);
    chk("t6_idle_we", 32'(we_v), 32'd0);
    chk("t6_reload_busy", 32'(oBUSY), 32'd1);
    for (int n = 0; n < 16; n++) cycle(1'b1, 1'b1, n);
    cycle(1'b0, 1'b0, 0);
    chk("t6_end_busy", 32'(oBUSY), 32'd0);
    chk("t6_writes", 32'(wr_n), 32'd32);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    chk("t6_done_idx", 32'(done_idx), 32'd31);
    chk("t6_gap_cycles", 32'(wr_cyc[16] - wr_cyc[15]), 32'd2);
    check_frame(0);
    check_frame(16);
    check_hits(2);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++) begin
        chk($sformatf("ram_re_b%0d_a%0d", b, a), 32'(mem_re[b][a]), 32'(exp_rev(a * 4 + b)));
        chk($sformatf("ram_im_b%0d_a%0d", b, a), 32'(mem_im[b][a]), 32'(neg(exp_rev(a * 4 + b))));
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
